// File: rtl/rx_buffer.sv
// rtl/rx_buffer.sv - receive-side byte FIFO behind the UART receiver, with overflow tracking
module rx_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Receive,
  input  logic [7:0]               Dout,
  input  logic                     parityErr,
  output logic                     ReceiveAck,
  input  logic                     rdEn,
  output logic [7:0]               rdData,
  output logic                     rdParityErr,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clrOverflow,
  output logic [7:0]               dropCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, ACK} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            push;
  logic            pop;
  logic            drop;
  logic            wr_en;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_nxt;
  logic [8:0]      mem [DEPTH];

  // Handshake state register; ReceiveAck is a direct decode of this flop
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake next state; a push is issued only on the IDLE->ACK transition
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (Receive) begin
          state_nxt = ACK;
          push      = 1'b1;
        end
      end
      ACK: begin
        if (!Receive) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ReceiveAck = (state == ACK);

  // A pop on a full FIFO frees the slot the concurrent push lands in
  assign pop   = rdEn & ~empty;
  assign drop  = push & full & ~pop;
  assign wr_en = push & ~drop;

  // Occupancy after this edge; flags are derived from it so they stay in step with count
  always_comb begin
    count_nxt = count;
    if (wr_en && !pop)      count_nxt = count + CW'(1);
    else if (pop && !wr_en) count_nxt = count - CW'(1);
  end

  // Pointers, occupancy and registered empty/full flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

  // Storage holds {parity flag, byte}; contents are left uninitialised on reset
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= {parityErr, Dout};
  end

  // Sticky overflow and saturating drop counter; a drop beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      dropCount <= 8'd0;
    end else if (drop) begin
      overflow  <= 1'b1;
      if (clrOverflow)             dropCount <= 8'd1;
      else if (dropCount != 8'hff) dropCount <= dropCount + 8'd1;
    end else if (clrOverflow) begin
      overflow  <= 1'b0;
      dropCount <= 8'd0;
    end
  end

  assign {rdParityErr, rdData} = mem[rd_ptr];

endmodule

// File: tb/tb_rx_buffer.sv
// tb/tb_rx_buffer.sv - scoreboard bench for rx_buffer with randomized receive/read traffic
module tb_rx_buffer;

  localparam int DEPTH = 16;

  logic                   clk;
  logic                   rst;
  logic                   Receive;
  logic [7:0]             Dout;
  logic                   parityErr;
  logic                   ReceiveAck;
  logic                   rdEn;
  logic [7:0]             rdData;
  logic                   rdParityErr;
  logic                   empty;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   clrOverflow;
  logic [7:0]             dropCount;

  int n_chk  = 0;
  int n_fail = 0;
  int rd_pct = 0;

  // reference model state
  logic [8:0] sb[$];
  int         m_cnt   = 0;
  bit         m_ack   = 0;
  bit         m_ovf   = 0;
  int         m_drops = 0;
  bit         started = 0;
  bit         ev_push, ev_pop, ev_drop;

  rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .Receive(Receive), .Dout(Dout), .parityErr(parityErr),
    .ReceiveAck(ReceiveAck), .rdEn(rdEn), .rdData(rdData), .rdParityErr(rdParityErr),
    .empty(empty), .full(full), .count(count), .overflow(overflow),
    .clrOverflow(clrOverflow), .dropCount(dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of accepted entries, occupancy, ack and drop bookkeeping
  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      sb.delete();
      m_cnt = 0; m_ack = 0; m_ovf = 0; m_drops = 0;
    end else begin
      ev_pop  = rdEn && (m_cnt > 0);
      ev_push = !m_ack && Receive;
      ev_drop = ev_push && (m_cnt == DEPTH) && !ev_pop;
      if (ev_push && !ev_drop) sb.push_back({parityErr, Dout});
      m_cnt = m_cnt + ((ev_push && !ev_drop) ? 1 : 0) - (ev_pop ? 1 : 0);
      if (!m_ack && Receive) m_ack = 1;
      else if (m_ack && !Receive) m_ack = 0;
      if (ev_drop) begin
        m_ovf   = 1;
        m_drops = clrOverflow ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
      end else if (clrOverflow) begin
        m_ovf = 0; m_drops = 0;
      end
    end
  end

  // Monitor: status every cycle, head entry compared whenever a pop is presented
  always @(negedge clk) begin
    if (started) begin
      chk("ReceiveAck", ReceiveAck, m_ack);
      chk("count", count, m_cnt);
      chk("empty", empty, m_cnt == 0);
      chk("full", full, m_cnt == DEPTH);
      chk("overflow", overflow, m_ovf);
      chk("dropCount", dropCount, m_drops);
      if (rdEn && m_cnt > 0) begin
        if (sb.size() == 0) begin
          chk("scoreboard_nonempty", 0, 1);
        end else begin
          logic [8:0] e;
          e = sb.pop_front();
          chk("rdData", rdData, e[7:0]);
          chk("rdParityErr", rdParityErr, e[8]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    rdEn        = (rd_pct > 0) && (int'($urandom_range(99)) < rd_pct);
    clrOverflow = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit pe, input int hold,
                           input bit pop_first, input bit clr_first);
    int n;
    tick();
    Receive = 1'b1; Dout = d; parityErr = pe;
    if (pop_first) rdEn = 1'b1;
    if (clr_first) clrOverflow = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!ReceiveAck && n < 8);
    chk("ack_rise", ReceiveAck, 1);
    repeat (hold) tick();
    Receive = 1'b0;
    n = 0;
    do begin tick(); n++; end while (ReceiveAck && n < 8);
    chk("ack_fall", ReceiveAck, 0);
  endtask

  task automatic pop_one();
    tick();
    rdEn = 1'b1;
    tick();
  endtask

  task automatic drain();
    int n;
    rd_pct = 0;
    n = 0;
    while (!empty && n < 2 * DEPTH + 4) begin pop_one(); n++; end
    chk("drain_empty", empty, 1);
  endtask

  task automatic clear_ovf();
    tick();
    clrOverflow = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ord [5];
    logic [7:0] v;
    ord[0] = 8'hff; ord[1] = 8'h00; ord[2] = 8'h0f; ord[3] = 8'hf0; ord[4] = 8'haa;
    rst = 1'b1; Receive = 1'b0; Dout = 8'h00; parityErr = 1'b0; rdEn = 1'b0; clrOverflow = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ack", ReceiveAck, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_dropCount", dropCount, 0);

    // single byte
    send_byte(8'h37, 0, 5, 0, 0);
    chk("single_count", count, 1);
    chk("single_data", rdData, 8'h37);
    chk("single_perr", rdParityErr, 0);
    pop_one();
    chk("single_empty", empty, 1);

    // ordering and parity
    for (int i = 0; i < 5; i++) send_byte(ord[i], i == 4, $urandom_range(2), 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("order_data", rdData, ord[i]);
      chk("order_perr", rdParityErr, i == 4);
      pop_one();
    end

    // full and overflow
    for (int i = 0; i < DEPTH + 3; i++) send_byte(8'h40 + 8'(i), 0, 0, 0, 0);
    chk("ovf_full", full, 1);
    chk("ovf_count", count, DEPTH);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", dropCount, 3);
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovf_read", rdData, 8'h40 + 8'(i));
      pop_one();
    end
    clear_ovf();
    chk("clr_flag", overflow, 0);
    chk("clr_drops", dropCount, 0);

    // full FIFO push with simultaneous pop
    for (int i = 0; i < DEPTH; i++) send_byte(8'h60 + 8'(i), 0, 0, 0, 0);
    send_byte(8'hee, 1, 1, 1, 0);
    chk("simfull_count", count, DEPTH);
    chk("simfull_ovf", overflow, 0);
    for (int i = 0; i < DEPTH; i++) begin
      v = (i == DEPTH - 1) ? 8'hee : 8'h61 + 8'(i);
      chk("simfull_read", rdData, v);
      pop_one();
    end

    // empty FIFO push with rdEn
    send_byte(8'h5a, 0, 0, 1, 0);
    chk("simempty_count", count, 1);
    pop_one();

    // drop together with clear, then saturation
    for (int i = 0; i < DEPTH; i++) send_byte(8'h80 + 8'(i), 0, 0, 0, 0);
    send_byte(8'h11, 0, 0, 0, 0);
    send_byte(8'h22, 0, 0, 0, 0);
    chk("pre_clr_drops", dropCount, 2);
    send_byte(8'h33, 0, 0, 0, 1);
    chk("dropclr_ovf", overflow, 1);
    chk("dropclr_drops", dropCount, 1);
    for (int i = 0; i < 256; i++) send_byte(8'(i), 0, 0, 0, 0);
    chk("sat_drops", dropCount, 255);
    clear_ovf();
    chk("sat_clr", dropCount, 0);
    drain();

    // stream across pointer wrap with interleaved reads
    rd_pct = 50;
    for (int i = 0; i < 3 * DEPTH; i++) send_byte(8'(i), 0, $urandom_range(1), 0, 0);
    drain();

    // reset mid-handshake, still-high Receive re-captured once
    tick();
    Receive = 1'b1; Dout = 8'hc3; parityErr = 1'b1;
    tick();
    chk("mid_ack", ReceiveAck, 1);
    rst = 1'b1;
    tick();
    chk("midrst_ack", ReceiveAck, 0);
    chk("midrst_empty", empty, 1);
    rst = 1'b0;
    tick();
    chk("recap_ack", ReceiveAck, 1);
    chk("recap_count", count, 1);
    tick(); tick();
    chk("recap_once", count, 1);
    Receive = 1'b0;
    tick();
    chk("recap_fall", ReceiveAck, 0);
    drain();

    // random traffic
    for (int i = 0; i < 150; i++) begin
      rd_pct = $urandom_range(100);
      send_byte(8'($urandom), 1'($urandom), $urandom_range(3), 0, $urandom_range(9) == 0);
    end
    drain();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
